// File: rtl/rv32i_types.sv
// rv32i_types: shared types for the pipeline hazard/fetch controller
package rv32i_types;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {F_RST, F_REQ, F_HOLD, F_DROP} fetch_state_t;
endpackage

// File: rtl/fetch_tracker.sv
// fetch_tracker: imem handshake FSM with a 1-entry IR hold buffer and a redirect-target latch
module fetch_tracker
  import rv32i_types::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_imem_resp,
  input  logic [XLEN-1:0] i_imem_rdata,
  input  logic [XLEN-1:0] i_branch_target,
  input  logic            i_redirect,
  input  logic            i_front_stall,
  output logic            o_imem_read,
  output logic [XLEN-1:0] o_if_ir,
  output logic            o_if_valid,
  output logic            o_load_pc,
  output logic            o_pc_redirect,
  output logic [XLEN-1:0] o_pc_redirect_addr,
  output logic            o_active
);
  fetch_state_t    r_state, w_next;
  logic [XLEN-1:0] r_hold, r_tgt;
  logic            w_cap, w_lat;

  assign o_active   = r_state != F_RST;
  assign o_if_valid = (r_state == F_REQ & i_imem_resp) | r_state == F_HOLD;

  // Next state and fetch-side outputs; a resp in F_DROP always redirects, even under a dmem stall, since the stale word must never reach IF/ID
  always_comb begin
    w_next             = r_state;
    o_imem_read        = 1'b0;
    o_if_ir            = '0;
    o_load_pc          = 1'b0;
    o_pc_redirect      = 1'b0;
    o_pc_redirect_addr = '0;
    w_cap              = 1'b0;
    w_lat              = 1'b0;
    case (r_state)
      F_RST: w_next = F_REQ;
      F_REQ: begin
        o_imem_read        = 1'b1;
        o_if_ir            = i_imem_rdata;
        o_load_pc          = i_imem_resp;
        o_pc_redirect      = i_imem_resp & i_redirect;
        o_pc_redirect_addr = (i_imem_resp & i_redirect) ? i_branch_target : '0;
        w_cap              = i_imem_resp & ~i_redirect & i_front_stall;
        w_lat              = ~i_imem_resp & i_redirect;
        w_next             = w_cap ? F_HOLD : w_lat ? F_DROP : F_REQ;
      end
      F_HOLD: begin
        o_if_ir            = r_hold;
        o_load_pc          = i_redirect;
        o_pc_redirect      = i_redirect;
        o_pc_redirect_addr = i_redirect ? i_branch_target : '0;
        w_next             = (i_redirect | ~i_front_stall) ? F_REQ : F_HOLD;
      end
      default: begin
        o_imem_read        = 1'b1;
        o_load_pc          = i_imem_resp;
        o_pc_redirect      = i_imem_resp;
        o_pc_redirect_addr = ~i_imem_resp ? '0 : i_redirect ? i_branch_target : r_tgt;
        w_lat              = ~i_imem_resp & i_redirect;
        w_next             = i_imem_resp ? F_REQ : F_DROP;
      end
    endcase
  end

  // State register, hold-buffer capture and redirect-target latch (newest redirect wins)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= F_RST;
      r_hold  <= '0;
      r_tgt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_cap) r_hold <= i_imem_rdata;
      if (w_lat) r_tgt <= i_branch_target;
    end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/fetch-handshake controller; PERF_CNT_EN adds saturating stall/redirect counters
module pipe_hazard_ctrl
  import rv32i_types::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int EX_STAGE   = 2,
  parameter int PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_read,
  input  logic                  imem_resp,
  input  logic [XLEN-1:0]       imem_rdata,
  input  logic                  dmem_read,
  input  logic                  dmem_write,
  input  logic                  dmem_resp,
  input  logic                  branch_take,
  input  logic [XLEN-1:0]       branch_target,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [4:0]            ex_rd,
  input  logic                  ex_is_load,
  output logic [XLEN-1:0]       if_ir,
  output logic                  load_pc,
  output logic                  pc_redirect,
  output logic [XLEN-1:0]       pc_redirect_addr,
  output logic [NUM_STAGES-2:0] reg_load,
  output logic [NUM_STAGES-2:0] reg_flush,
  output logic [PERF_W-1:0]     perf_stall_cnt,
  output logic [PERF_W-1:0]     perf_flush_cnt
);
  logic w_mem_busy, w_load_use, w_go, w_redirect, w_front_stall, w_if_valid, w_active;

  assign w_mem_busy    = (dmem_read | dmem_write) & ~dmem_resp;
  assign w_load_use    = ex_is_load & (ex_rd != '0) &
                         ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  assign w_go          = w_active & ~w_mem_busy;
  assign w_redirect    = w_go & branch_take;
  assign w_front_stall = w_mem_busy | (w_load_use & ~w_redirect);

  fetch_tracker u_fetch (
    .clk                (clk),
    .rst                (rst),
    .i_imem_resp        (imem_resp),
    .i_imem_rdata       (imem_rdata),
    .i_branch_target    (branch_target),
    .i_redirect         (w_redirect),
    .i_front_stall      (w_front_stall),
    .o_imem_read        (imem_read),
    .o_if_ir            (if_ir),
    .o_if_valid         (w_if_valid),
    .o_load_pc          (load_pc),
    .o_pc_redirect      (pc_redirect),
    .o_pc_redirect_addr (pc_redirect_addr),
    .o_active           (w_active)
  );

  // Per-register enables: redirect flushes up to EX, load-use holds the front and bubbles ID/EX, IF/ID follows fetch otherwise
  always_comb begin
    reg_load  = '0;
    reg_flush = '0;
    for (int r = 0; r < NUM_STAGES - 1; r++) begin
      reg_flush[r] = w_go & (w_redirect ? (r < EX_STAGE) :
                             w_load_use ? (r == EX_STAGE - 1) : ((r == 0) & ~w_if_valid));
      reg_load[r]  = w_go & ((w_redirect | w_load_use) ? (r >= EX_STAGE) : ((r != 0) | w_if_valid));
    end
  end

`ifdef PERF_CNT_EN
  logic [PERF_W-1:0] r_stall_cnt, r_flush_cnt;

  // Saturating per-cycle stall and redirect counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_active & (w_mem_busy | w_load_use) & ~&r_stall_cnt) r_stall_cnt <= r_stall_cnt + PERF_W'(1);
      if (w_redirect & ~&r_flush_cnt) r_flush_cnt <= r_flush_cnt + PERF_W'(1);
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_flush_cnt = r_flush_cnt;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus randomized traffic against a behavioural model
module tb_pipe_hazard_ctrl;
  localparam int NS = 5;
  localparam int EX = 2;
  localparam int PW = 32;
  localparam int NR = NS - 1;
`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, imem_resp, dmem_read, dmem_write, dmem_resp, branch_take;
  logic [31:0]   imem_rdata, branch_target;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, ex_is_load;
  logic          imem_read, load_pc, pc_redirect;
  logic [31:0]   if_ir, pc_redirect_addr;
  logic [NR-1:0] reg_load, reg_flush;
  logic [PW-1:0] perf_stall_cnt, perf_flush_cnt;

  pipe_hazard_ctrl #(.NUM_STAGES(NS), .EX_STAGE(EX), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst), .imem_read(imem_read), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
    .branch_take(branch_take), .branch_target(branch_target),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .if_ir(if_ir), .load_pc(load_pc),
    .pc_redirect(pc_redirect), .pc_redirect_addr(pc_redirect_addr),
    .reg_load(reg_load), .reg_flush(reg_flush),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  int cmp_n = 0;
  int err_n = 0;

  // Behavioural model: booting flag, held-word flag, dropping-fetch flag
  bit            m_boot = 1'b1, m_hv = 1'b0, m_drop = 1'b0;
  logic [31:0]   m_hold = '0, m_tgt = '0;
  logic [PW-1:0] m_sc = '0, m_fc = '0;
  bit            m_busy, m_lu, m_redir, m_fstall;
  bit            e_ird, e_lpc, e_prd;
  logic [31:0]   e_addr, e_ir;
  logic [NR-1:0] e_load, e_flush;

  function automatic void model_comb();
    logic [NR-1:0] lo;
    bit go, got, avail;
    lo       = NR'((1 << EX) - 1);
    m_busy   = (dmem_read || dmem_write) && !dmem_resp;
    m_lu     = ex_is_load && ex_rd != 0 && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    go       = !m_boot && !m_busy;
    m_redir  = go && branch_take;
    m_fstall = m_busy || (m_lu && !m_redir);
    e_ird    = !m_boot && !m_hv;
    got      = e_ird && imem_resp;
    avail    = m_hv || (got && !m_drop);
    e_lpc    = got || (m_hv && m_redir);
    e_prd    = (got && (m_drop || m_redir)) || (m_hv && m_redir);
    e_addr   = m_redir ? branch_target : m_tgt;
    e_ir     = m_hv ? m_hold : imem_rdata;
    if (!go) begin
      e_load = '0; e_flush = '0;
    end else if (m_redir) begin
      e_load = ~lo; e_flush = lo;
    end else if (m_lu) begin
      e_load = ~lo; e_flush = NR'(1 << (EX - 1));
    end else begin
      e_load = avail ? '1 : ~NR'(1); e_flush = avail ? '0 : NR'(1);
    end
  endfunction

  function automatic void model_clk();
    model_comb();
    if (rst) begin
      m_boot = 1'b1; m_hv = 1'b0; m_drop = 1'b0; m_sc = '0; m_fc = '0;
    end else begin
      if (!m_boot && (m_busy || m_lu) && m_sc != '1) m_sc = m_sc + 1;
      if (m_redir && m_fc != '1) m_fc = m_fc + 1;
      if (m_boot) m_boot = 1'b0;
      else if (m_hv) begin
        if (m_redir || !m_fstall) m_hv = 1'b0;
      end else if (m_drop) begin
        if (imem_resp) m_drop = 1'b0;
        else if (m_redir) m_tgt = branch_target;
      end else if (imem_resp && !m_redir && m_fstall) begin
        m_hv = 1'b1; m_hold = imem_rdata;
      end else if (!imem_resp && m_redir) begin
        m_drop = 1'b1; m_tgt = branch_target;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_clk();
    #1;
  endtask

  task automatic idle();
    imem_resp = 0; imem_rdata = '0; dmem_read = 0; dmem_write = 0; dmem_resp = 0;
    branch_take = 0; branch_target = '0; id_rs1 = '0; id_rs2 = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_rd = '0; ex_is_load = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle(); tick(); tick(); rst = 0; tick();
  endtask

  task automatic test_reset();
    rst = 1; idle(); tick(); tick();
    @(negedge clk);
    cmp_n++; if (imem_read !== 1'b0) begin err_n++; $display("FAIL rst_imem_read: got %b want 0", imem_read); end
    cmp_n++; if (load_pc !== 1'b0) begin err_n++; $display("FAIL rst_load_pc: got %b want 0", load_pc); end
    cmp_n++; if (pc_redirect !== 1'b0) begin err_n++; $display("FAIL rst_pc_redirect: got %b want 0", pc_redirect); end
    cmp_n++; if (reg_load !== '0) begin err_n++; $display("FAIL rst_reg_load: got %b want 0", reg_load); end
    cmp_n++; if (reg_flush !== '0) begin err_n++; $display("FAIL rst_reg_flush: got %b want 0", reg_flush); end
    cmp_n++; if (perf_stall_cnt !== '0) begin err_n++; $display("FAIL rst_stall_cnt: got %0d want 0", perf_stall_cnt); end
    cmp_n++; if (perf_flush_cnt !== '0) begin err_n++; $display("FAIL rst_flush_cnt: got %0d want 0", perf_flush_cnt); end
    rst = 0;
    tick();
    @(negedge clk);
    cmp_n++; if (imem_read !== 1'b1) begin err_n++; $display("FAIL boot_imem_read: got %b want 1", imem_read); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      imem_resp = 1; imem_rdata = $urandom;
      @(negedge clk);
      cmp_n++; if (imem_read !== 1'b1) begin err_n++; $display("FAIL stream_imem_read: got %b want 1", imem_read); end
      cmp_n++; if (reg_load !== 4'b1111) begin err_n++; $display("FAIL stream_reg_load: got %b want 1111", reg_load); end
      cmp_n++; if (reg_flush !== 4'b0000) begin err_n++; $display("FAIL stream_reg_flush: got %b want 0000", reg_flush); end
      cmp_n++; if (load_pc !== 1'b1) begin err_n++; $display("FAIL stream_load_pc: got %b want 1", load_pc); end
      cmp_n++; if (if_ir !== imem_rdata) begin err_n++; $display("FAIL stream_if_ir: got %h want %h", if_ir, imem_rdata); end
      tick();
    end
    idle();
  endtask

  task automatic test_load_use();
    idle(); ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    @(negedge clk);
    cmp_n++; if (reg_load !== 4'b1100) begin err_n++; $display("FAIL lu_reg_load: got %b want 1100", reg_load); end
    cmp_n++; if (reg_flush !== 4'b0010) begin err_n++; $display("FAIL lu_reg_flush: got %b want 0010", reg_flush); end
    cmp_n++; if (load_pc !== 1'b0) begin err_n++; $display("FAIL lu_load_pc: got %b want 0", load_pc); end
    tick();
    ex_rd = 0; id_rs1 = 0;
    @(negedge clk);
    cmp_n++; if (reg_load !== 4'b1110) begin err_n++; $display("FAIL lu_x0_reg_load: got %b want 1110", reg_load); end
    cmp_n++; if (reg_flush !== 4'b0001) begin err_n++; $display("FAIL lu_x0_reg_flush: got %b want 0001", reg_flush); end
    tick();
    ex_rd = 7; id_rs1 = 7; id_use_rs1 = 0; id_rs2 = 7; id_use_rs2 = 1;
    @(negedge clk);
    cmp_n++; if (reg_flush !== 4'b0010) begin err_n++; $display("FAIL lu_rs2_reg_flush: got %b want 0010", reg_flush); end
    tick();
    idle();
  endtask

  task automatic test_mem_stall();
    logic [31:0] w;
    w = $urandom;
    idle(); dmem_read = 1; imem_resp = 1; imem_rdata = w;
    @(negedge clk);
    cmp_n++; if (reg_load !== '0) begin err_n++; $display("FAIL ms_cap_reg_load: got %b want 0000", reg_load); end
    cmp_n++; if (load_pc !== 1'b1) begin err_n++; $display("FAIL ms_cap_load_pc: got %b want 1", load_pc); end
    tick();
    imem_resp = 0; imem_rdata = ~w;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cmp_n++; if (reg_load !== '0) begin err_n++; $display("FAIL ms_wait_reg_load: got %b want 0000", reg_load); end
      cmp_n++; if (imem_read !== 1'b0) begin err_n++; $display("FAIL ms_wait_imem_read: got %b want 0", imem_read); end
      cmp_n++; if (load_pc !== 1'b0) begin err_n++; $display("FAIL ms_wait_load_pc: got %b want 0", load_pc); end
      tick();
    end
    dmem_resp = 1;
    @(negedge clk);
    cmp_n++; if (reg_load !== 4'b1111) begin err_n++; $display("FAIL ms_rel_reg_load: got %b want 1111", reg_load); end
    cmp_n++; if (if_ir !== w) begin err_n++; $display("FAIL ms_rel_if_ir: got %h want %h", if_ir, w); end
    cmp_n++; if (load_pc !== 1'b0) begin err_n++; $display("FAIL ms_rel_load_pc: got %b want 0", load_pc); end
    tick();
    idle();
    @(negedge clk);
    cmp_n++; if (imem_read !== 1'b1) begin err_n++; $display("FAIL ms_after_imem_read: got %b want 1", imem_read); end
  endtask

  task automatic test_branch_drop();
    idle(); branch_take = 1; branch_target = 32'h60;
    @(negedge clk);
    cmp_n++; if (reg_flush !== 4'b0011) begin err_n++; $display("FAIL br_reg_flush: got %b want 0011", reg_flush); end
    cmp_n++; if (reg_load !== 4'b1100) begin err_n++; $display("FAIL br_reg_load: got %b want 1100", reg_load); end
    cmp_n++; if (load_pc !== 1'b0) begin err_n++; $display("FAIL br_load_pc: got %b want 0", load_pc); end
    tick();
    idle();
    @(negedge clk);
    cmp_n++; if (imem_read !== 1'b1 || load_pc !== 1'b0) begin err_n++; $display("FAIL br_wait: got read=%b pc=%b want read=1 pc=0", imem_read, load_pc); end
    tick();
    imem_resp = 1; imem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    cmp_n++; if (load_pc !== 1'b1 || pc_redirect !== 1'b1) begin err_n++; $display("FAIL br_resp_pc: got load=%b redir=%b want 1 1", load_pc, pc_redirect); end
    cmp_n++; if (pc_redirect_addr !== 32'h60) begin err_n++; $display("FAIL br_resp_addr: got %h want 00000060", pc_redirect_addr); end
    cmp_n++; if (reg_load[0] !== 1'b0) begin err_n++; $display("FAIL br_resp_drop: got %b want 0", reg_load[0]); end
    tick();
    idle();
  endtask

  task automatic test_branch_vs_load_use();
    idle(); imem_resp = 1; imem_rdata = $urandom; branch_take = 1; branch_target = 32'h80;
    ex_is_load = 1; ex_rd = 9; id_rs2 = 9; id_use_rs2 = 1;
    @(negedge clk);
    cmp_n++; if (reg_flush[1:0] !== 2'b11) begin err_n++; $display("FAIL bvl_reg_flush: got %b want 11", reg_flush[1:0]); end
    cmp_n++; if (reg_load[0] !== 1'b0) begin err_n++; $display("FAIL bvl_reg_load0: got %b want 0", reg_load[0]); end
    cmp_n++; if (pc_redirect !== 1'b1 || pc_redirect_addr !== 32'h80) begin err_n++; $display("FAIL bvl_redirect: got %b %h want 1 00000080", pc_redirect, pc_redirect_addr); end
    tick();
    idle();
  endtask

  task automatic test_perf();
    do_reset();
    dmem_read = 1;
    for (int i = 0; i < 3; i++) tick();
    dmem_resp = 1; tick();
    idle(); branch_take = 1; branch_target = 32'h40; imem_resp = 1; tick();
    idle();
    @(negedge clk);
    cmp_n++; if (perf_stall_cnt !== (PERF ? PW'(3) : '0)) begin err_n++; $display("FAIL perf_stall: got %0d want %0d", perf_stall_cnt, PERF ? 3 : 0); end
    cmp_n++; if (perf_flush_cnt !== (PERF ? PW'(1) : '0)) begin err_n++; $display("FAIL perf_flush: got %0d want %0d", perf_flush_cnt, PERF ? 1 : 0); end
    branch_take = 1; branch_target = 32'h44; tick();
    idle();
    @(negedge clk);
    cmp_n++; if (perf_flush_cnt !== (PERF ? PW'(2) : '0)) begin err_n++; $display("FAIL perf_flush2: got %0d want %0d", perf_flush_cnt, PERF ? 2 : 0); end
    rst = 1; tick();
    @(negedge clk);
    cmp_n++; if (imem_read !== 1'b0 || pc_redirect !== 1'b0) begin err_n++; $display("FAIL drop_rst: got read=%b redir=%b want 0 0", imem_read, pc_redirect); end
    cmp_n++; if (perf_stall_cnt !== '0 || perf_flush_cnt !== '0) begin err_n++; $display("FAIL drop_rst_cnt: got %0d %0d want 0 0", perf_stall_cnt, perf_flush_cnt); end
    rst = 0; tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      rst           = $urandom_range(0, 63) == 0;
      imem_resp     = $urandom_range(0, 1) == 1;
      imem_rdata    = $urandom;
      dmem_read     = $urandom_range(0, 3) == 0;
      dmem_write    = $urandom_range(0, 7) == 0;
      dmem_resp     = $urandom_range(0, 1) == 1;
      branch_take   = $urandom_range(0, 4) == 0;
      branch_target = $urandom;
      id_rs1        = 5'($urandom_range(0, 3));
      id_rs2        = 5'($urandom_range(0, 3));
      ex_rd         = 5'($urandom_range(0, 3));
      id_use_rs1    = $urandom_range(0, 1) == 1;
      id_use_rs2    = $urandom_range(0, 1) == 1;
      ex_is_load    = $urandom_range(0, 1) == 1;
      @(negedge clk);
      model_comb();
      cmp_n++; if (imem_read !== e_ird) begin err_n++; $display("FAIL rnd_imem_read @%0d: got %b want %b", i, imem_read, e_ird); end
      cmp_n++; if (load_pc !== e_lpc) begin err_n++; $display("FAIL rnd_load_pc @%0d: got %b want %b", i, load_pc, e_lpc); end
      cmp_n++; if (pc_redirect !== e_prd) begin err_n++; $display("FAIL rnd_pc_redirect @%0d: got %b want %b", i, pc_redirect, e_prd); end
      cmp_n++; if (reg_load !== e_load) begin err_n++; $display("FAIL rnd_reg_load @%0d: got %b want %b", i, reg_load, e_load); end
      cmp_n++; if (reg_flush !== e_flush) begin err_n++; $display("FAIL rnd_reg_flush @%0d: got %b want %b", i, reg_flush, e_flush); end
      if (e_prd) begin
        cmp_n++; if (pc_redirect_addr !== e_addr) begin err_n++; $display("FAIL rnd_addr @%0d: got %h want %h", i, pc_redirect_addr, e_addr); end
      end
      if (e_load[0]) begin
        cmp_n++; if (if_ir !== e_ir) begin err_n++; $display("FAIL rnd_if_ir @%0d: got %h want %h", i, if_ir, e_ir); end
      end
      cmp_n++; if (perf_stall_cnt !== (PERF ? m_sc : '0)) begin err_n++; $display("FAIL rnd_stall_cnt @%0d: got %0d want %0d", i, perf_stall_cnt, PERF ? m_sc : '0); end
      cmp_n++; if (perf_flush_cnt !== (PERF ? m_fc : '0)) begin err_n++; $display("FAIL rnd_flush_cnt @%0d: got %0d want %0d", i, perf_flush_cnt, PERF ? m_fc : '0); end
      tick();
    end
    rst = 0; idle();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_stream();
    test_load_use();
    test_mem_stall();
    test_branch_drop();
    test_branch_vs_load_use();
    test_perf();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
